// File: rtl/muldiv_arbiter_if.sv
// Request/response bundle between the two execute stages, the arbiter and the
// shared multiply/divide unit.
interface muldiv_arbiter_if;
  logic        req_0, req_1;
  logic        div_0, div_1;
  logic        sgn_0, sgn_1;
  logic [31:0] a_0, b_0, a_1, b_1;
  logic        stall_0, stall_1;
  logic        done_0, done_1;
  logic [31:0] hi_out, lo_out;
  logic        unit_start;
  logic        unit_div, unit_sgn;
  logic [31:0] unit_a, unit_b;
  logic [31:0] unit_hi, unit_lo;
  logic        busy;

  // Arbiter side.
  modport slave (
    input  req_0, req_1, div_0, div_1, sgn_0, sgn_1,
    input  a_0, b_0, a_1, b_1, unit_hi, unit_lo,
    output stall_0, stall_1, done_0, done_1, hi_out, lo_out,
    output unit_start, unit_div, unit_sgn, unit_a, unit_b, busy
  );

  // Cores plus shared unit side.
  modport master (
    output req_0, req_1, div_0, div_1, sgn_0, sgn_1,
    output a_0, b_0, a_1, b_1, unit_hi, unit_lo,
    input  stall_0, stall_1, done_0, done_1, hi_out, lo_out,
    input  unit_start, unit_div, unit_sgn, unit_a, unit_b, busy
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin sharing of one iterative multiply/divide unit between two cores:
// grant, start the unit, count its fixed latency, capture HI/LO, pulse done.
module muldiv_arbiter #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  muldiv_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, RESP, DZ} state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic        last_grant_reg;
  logic        gnt_reg;

  logic        any_req;
  logic        pick_1;
  logic        sel_div, sel_sgn;
  logic [31:0] sel_a, sel_b;

  // On a tie the core that was not granted last wins.
  always_comb begin
    any_req = bus.req_0 | bus.req_1;
    pick_1  = bus.req_1 & (~bus.req_0 | ~last_grant_reg);
    sel_div = pick_1 ? bus.div_1 : bus.div_0;
    sel_sgn = pick_1 ? bus.sgn_1 : bus.sgn_0;
    sel_a   = pick_1 ? bus.a_1   : bus.a_0;
    sel_b   = pick_1 ? bus.b_1   : bus.b_0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      gnt_reg        <= 1'b0;
      bus.unit_start <= 1'b0;
      bus.unit_div   <= 1'b0;
      bus.unit_sgn   <= 1'b0;
      bus.unit_a     <= '0;
      bus.unit_b     <= '0;
      bus.hi_out     <= '0;
      bus.lo_out     <= '0;
      bus.done_0     <= 1'b0;
      bus.done_1     <= 1'b0;
    end else begin
      bus.unit_start <= 1'b0;
      bus.done_0     <= 1'b0;
      bus.done_1     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            gnt_reg        <= pick_1;
            last_grant_reg <= pick_1;
            bus.unit_div   <= sel_div;
            bus.unit_sgn   <= sel_sgn;
            bus.unit_a     <= sel_a;
            bus.unit_b     <= sel_b;
            if (sel_div && (sel_b == 32'd0)) begin
              state_reg <= DZ;
            end else begin
              state_reg      <= RUN;
              cnt_reg        <= sel_div ? DIV_LOAD : MULT_LOAD;
              bus.unit_start <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cnt_reg == 6'd0) begin
            bus.hi_out <= bus.unit_hi;
            bus.lo_out <= bus.unit_lo;
            bus.done_0 <= ~gnt_reg;
            bus.done_1 <= gnt_reg;
            state_reg  <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 6'd1;
          end
        end
        DZ: begin
          // Divide by zero is answered locally; the shared unit stays idle.
          bus.hi_out <= bus.unit_a;
          bus.lo_out <= 32'hFFFF_FFFF;
          bus.done_0 <= ~gnt_reg;
          bus.done_1 <= gnt_reg;
          state_reg  <= RESP;
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_0 = bus.req_0 & ~bus.done_0;
  assign bus.stall_1 = bus.req_1 & ~bus.done_1;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a latency-accurate model of the
// shared unit that only presents its result in the cycle it is due.
module tb_muldiv_arbiter;

  localparam int unsigned MULT_N = 4;
  localparam int unsigned DIV_N  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_arbiter_if bus();

  muldiv_arbiter #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared unit model: result valid only in the N-th RUN cycle.
  logic [6:0]  u_cnt;
  logic [63:0] u_prod;
  logic [31:0] u_quo, u_rem;
  logic [6:0]  u_due;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            u_cnt <= '0;
    else if (bus.unit_start)              u_cnt <= 7'd1;
    else if (u_cnt != 0 && u_cnt < 7'd100) u_cnt <= u_cnt + 7'd1;
  end

  always_comb begin
    u_prod = 64'd0;
    u_quo  = 32'd0;
    u_rem  = 32'd0;
    u_due  = bus.unit_div ? 7'(DIV_N - 1) : 7'(MULT_N - 1);
    if (bus.unit_sgn) begin
      u_prod = $signed({{32{bus.unit_a[31]}}, bus.unit_a}) * $signed({{32{bus.unit_b[31]}}, bus.unit_b});
      if (bus.unit_b != 0) begin
        u_quo = $signed(bus.unit_a) / $signed(bus.unit_b);
        u_rem = $signed(bus.unit_a) % $signed(bus.unit_b);
      end
    end else begin
      u_prod = {32'd0, bus.unit_a} * {32'd0, bus.unit_b};
      if (bus.unit_b != 0) begin
        u_quo = bus.unit_a / bus.unit_b;
        u_rem = bus.unit_a % bus.unit_b;
      end
    end
    if (u_cnt == u_due) begin
      bus.unit_hi = bus.unit_div ? u_rem : u_prod[63:32];
      bus.unit_lo = bus.unit_div ? u_quo : u_prod[31:0];
    end else begin
      bus.unit_hi = 32'hDEAD_BEEF;
      bus.unit_lo = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (bus.done_0 || bus.done_1)
      $display("txn core=%0d hi=%h lo=%h", bus.done_1, bus.hi_out, bus.lo_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    next();
    reset = 1'b0;
    next();
  endtask

  task automatic set_core(input int c, input logic dv, input logic sg,
                          input logic [31:0] a, input logic [31:0] b);
    if (c == 0) begin
      bus.div_0 = dv; bus.sgn_0 = sg; bus.a_0 = a; bus.b_0 = b;
    end else begin
      bus.div_1 = dv; bus.sgn_1 = sg; bus.a_1 = a; bus.b_1 = b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    bus.req_0 = 0; bus.req_1 = 0;
    set_core(0, 0, 0, 0, 0);
    set_core(1, 0, 0, 0, 0);
    do_reset();

    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi_out, 0);
    check("rst_lo", bus.lo_out, 0);

    // Reset in the middle of a RUN.
    set_core(0, 0, 0, 11, 11);
    bus.req_0 = 1;
    next();
    next();
    check("mid_busy_before", bus.busy, 1);
    reset = 1;
    bus.req_0 = 0;
    next();
    check("mid_busy", bus.busy, 0);
    check("mid_stall0", bus.stall_0, 0);
    check("mid_done0", bus.done_0, 0);
    check("mid_hi", bus.hi_out, 0);
    check("mid_lo", bus.lo_out, 0);
    check("mid_unit_a", bus.unit_a, 0);
    reset = 0;
    next();
    set_core(0, 0, 0, 1, 2);
    set_core(1, 0, 0, 3, 4);
    bus.req_0 = 1; bus.req_1 = 1;
    next();
    check("mid_tie_start", bus.unit_start, 1);
    check("mid_tie_core0", bus.unit_a, 1);
    bus.req_1 = 0;
    for (int t = 2; t <= 5; t++) begin
      next();
      check("mid_done0_t", bus.done_0, 32'(t == 5));
    end
    check("mid_lo_res", bus.lo_out, 2);
    bus.req_0 = 0;
    next();

    // Single multiply 7*6.
    do_reset();
    set_core(0, 0, 0, 7, 6);
    bus.req_0 = 1;
    #1;
    for (int t = 0; t <= 5; t++) begin
      if (t > 0) next();
      check("mul_start", bus.unit_start, 32'(t == 1));
      check("mul_stall0", bus.stall_0, 32'(t <= 4));
      check("mul_done0", bus.done_0, 32'(t == 5));
      if (t == 5) begin
        check("mul_lo", bus.lo_out, 42);
        check("mul_hi", bus.hi_out, 0);
        bus.req_0 = 0;
      end
    end
    next();
    check("mul_idle", bus.busy, 0);

    // Tie: core 0 multiply 3*5, core 1 divide 100/7.
    do_reset();
    set_core(0, 0, 0, 3, 5);
    set_core(1, 1, 0, 100, 7);
    bus.req_0 = 1; bus.req_1 = 1;
    #1;
    for (int t = 0; t <= 39; t++) begin
      if (t > 0) next();
      check("tie_start", bus.unit_start, 32'(t == 1 || t == 7));
      check("tie_done0", bus.done_0, 32'(t == 5));
      check("tie_done1", bus.done_1, 32'(t == 39));
      check("tie_stall1", bus.stall_1, 32'(t <= 38));
      if (t == 5) begin
        check("tie_lo0", bus.lo_out, 15);
        check("tie_hi0", bus.hi_out, 0);
        bus.req_0 = 0;
      end
      if (t == 7) begin
        check("tie_unit_a1", bus.unit_a, 100);
        check("tie_unit_div1", bus.unit_div, 1);
      end
      if (t == 39) begin
        check("tie_lo1", bus.lo_out, 14);
        check("tie_hi1", bus.hi_out, 2);
        bus.req_1 = 0;
      end
    end
    next();

    // Fairness: both cores keep requesting for four operations.
    do_reset();
    set_core(0, 0, 0, 2, 3);
    set_core(1, 0, 0, 4, 5);
    bus.req_0 = 1; bus.req_1 = 1;
    ndone = 0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      next();
      if (bus.done_0 || bus.done_1) begin
        check("fair_core", bus.done_1, 32'(ndone % 2));
        check("fair_single", bus.done_0 & bus.done_1, 0);
        check("fair_lo", bus.lo_out, (ndone % 2) ? 32'd20 : 32'd6);
        ndone++;
        if (ndone == 4) begin
          bus.req_0 = 0; bus.req_1 = 0;
        end
      end
    end
    check("fair_count", ndone, 4);
    bus.req_0 = 0; bus.req_1 = 0;
    next();

    // Divide by zero on core 1.
    do_reset();
    set_core(1, 1, 0, 5, 0);
    bus.req_1 = 1;
    #1;
    for (int t = 0; t <= 3; t++) begin
      if (t > 0) next();
      check("dz_start", bus.unit_start, 0);
      check("dz_done1", bus.done_1, 32'(t == 2));
      check("dz_busy", bus.busy, 32'(t == 1 || t == 2));
      if (t == 2) begin
        check("dz_hi", bus.hi_out, 5);
        check("dz_lo", bus.lo_out, 32'hFFFF_FFFF);
        bus.req_1 = 0;
      end
    end

    // Operands latched at grant stay fixed while the core changes them.
    do_reset();
    set_core(0, 0, 1, 9, 9);
    bus.req_0 = 1;
    for (int t = 1; t <= 5; t++) begin
      next();
      if (t == 1) bus.a_0 = 1234;
      if (t <= 4) check("stab_unit_a", bus.unit_a, 9);
      if (t == 5) begin
        check("stab_done0", bus.done_0, 1);
        check("stab_lo", bus.lo_out, 81);
        check("stab_hi", bus.hi_out, 0);
        bus.req_0 = 0;
      end
    end
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
